hpbar_anim: RTL and testbench
=============================

// Module: hpbar_anim
// PURPOSE
//  Animated HP-bar geometry generator for the battle HUD, successor to the static bar.
//  Uses a multi-cycle restoring divider to compute target width = F_WIDTH*remain/total,
//  then slides the displayed bar toward the target one step per frame tick.
//  Feeds the rectangle renderer with the same lt/br corner outputs as the static bar.
// PARAMETERS
//  F_WIDTH    300  full bar width in pixels (1..1023)
//  F_HEIGHT   16   bar height in pixels
//  FX         240  left x coordinate
//  FY         400  top y coordinate
//  HP_W       16   width of the HP inputs
//  DRAIN_STEP 2    pixels removed per tick while shrinking
//  HEAL_STEP  1    pixels added per tick while growing
//  LOW_W      60   o_low asserts when displayed width < LOW_W
//  GHOST_HOLD 30   ticks the damage trail holds before it drains (ghost feature only)
// PORTS
//  i_clk        in   1     system clock
//  i_rst_n      in   1     asynchronous active-low reset
//  i_tick       in   1     one-cycle frame strobe (one per frame)
//  i_update     in   1     one-cycle strobe that samples i_total_hp/i_remain_hp
//  i_total_hp   in   HP_W  maximum HP
//  i_remain_hp  in   HP_W  current HP
//  o_lt_x       out  16    constant FX
//  o_lt_y       out  16    constant FY
//  o_br_x       out  16    FX + displayed width (registered)
//  o_br_y       out  16    constant FY+F_HEIGHT
//  o_ghost_br_x out  16    FX + ghost-trail width (registered)
//  o_busy       out  1     divide in progress
//  o_settled    out  1     displayed width == target and !o_busy
//  o_low        out  1     displayed width < LOW_W
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE; tgt_w=cur_w=ghost_w=F_WIDTH; o_br_x=o_ghost_br_x=FX+F_WIDTH;
//   o_busy=0; o_settled=1; o_low=0 (or 1 if F_WIDTH<LOW_W). Deassertion takes effect at the next clock edge.
//  PW = HP_W + $clog2(F_WIDTH+1) (product width). LAT = PW+2 cycles.
//  FSM: IDLE -(i_update)-> MUL: latch remain, total, o_busy=1.
//   MUL (1 cycle): prod = remain*F_WIDTH; clamp remain to total first.
//   DIV (PW cycles): restoring divide, one quotient bit per cycle.
//   DONE (1 cycle): tgt_w <= min(quotient, F_WIDTH); o_busy=0; next state IDLE.
//   tgt_w therefore updates LAT cycles after the accepted i_update.
//  total==0: skip DIV; tgt_w=0 in DONE (LAT=3 cycles). remain>total: target is F_WIDTH.
//  i_update while busy: set a pending flag (multiple strobes collapse into one). In DONE with
//   the flag set, go directly to MUL, re-sample the inputs that cycle, and keep o_busy high.
//  Animation is evaluated on i_tick only, using tgt_w as registered before that edge:
//   cur_w>tgt_w: cur_w -= DRAIN_STEP, saturating at tgt_w.
//   cur_w<tgt_w: cur_w += HEAL_STEP, saturating at tgt_w. Never goes below 0 or above F_WIDTH.
//  i_tick in the same cycle as the DONE write: the step uses the old tgt_w.
//  Animation continues during o_busy. All outputs are registered; corner outputs are zero-extended to 16 bits.
// CONFIGURATION
//  HPBAR_GHOST_EN defined: damage-trail ghost bar.
//   ghost_w follows cur_w immediately whenever cur_w >= ghost_w.
//   When cur_w drops below ghost_w: load hold counter = GHOST_HOLD; decrement once per tick;
//    at 0, ghost_w -= 1 per tick, saturating at cur_w.
//   Further damage during the hold reloads the counter.
//  HPBAR_GHOST_EN undefined: no hold counter or ghost register; o_ghost_br_x = o_br_x every cycle.
// STRUCTURE
//  hpbar_pkg: FSM state enum (IDLE, MUL, DIV, DONE); pixel-width typedef ($clog2(F_WIDTH+1) bits);
//   function pw(HP_W, F_WIDTH).
//  Sub-module hp_seq_div: parametrised restoring divider (start/done, dividend PW bits,
//   divisor HP_W bits, PW-cycle latency). The FSM and animation stay in hpbar_anim.
// TESTING (defaults unless stated; PW=25, LAT=27)
//  Reset: o_br_x=540, o_ghost_br_x=540, o_settled=1, o_busy=0; assert i_rst_n=0 mid-DIV ->
//   all outputs return to reset values asynchronously.
//  update total=100 remain=50 -> o_busy high for 27 cycles, tgt_w=150; after 75 ticks
//   o_br_x=390 and o_settled=1; o_low stays 0.
//  total=0 remain=7 -> tgt 0 after 3 cycles; o_br_x drains to 240; o_low=1 once width<60.
//   remain=200 total=100 -> width 300.
//  Two i_update strobes 5 cycles apart (50/100, then 10/100) -> exactly one restart;
//   final tgt_w=30; o_busy stays high continuously for 54 cycles.
//  HPBAR_GHOST_EN: 300->150 drop -> o_ghost_br_x holds 540 for 30 ticks, then steps -1/tick to 390;
//   heal to 200 -> ghost tracks cur_w.
//  Without HPBAR_GHOST_EN: o_ghost_br_x == o_br_x every cycle of all scenarios above.

Source files
------------

// File: rtl/hpbar_pkg.sv
// hpbar_pkg
//   Shared types and helpers for the animated HP bar (hpbar_anim) and its
//   sequential divider (hp_seq_div).
//   Contents:
//     state_t      control FSM states IDLE / MUL / DIV / DONE
//     px_t         pixel-width type, wide enough for any legal bar width (1..1023)
//     pw()         product width HP_W + $clog2(F_WIDTH+1) used by the divider
//     step_toward  one animation step of a width toward its target
package hpbar_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   localparam int MAX_F_WIDTH = 1023;

   // Sized for the widest legal bar so one type serves every parameterisation
   typedef logic [$clog2(MAX_F_WIDTH + 1) - 1:0] px_t;

   function automatic int pw(input int hp_w, input int f_width);
      return hp_w + $clog2(f_width + 1);
   endfunction

   // Moves cur toward tgt by down (shrinking) or up (growing), never overshooting.
   // The result always lies between cur and tgt, so it cannot wrap.
   function automatic px_t step_toward(input px_t cur, input px_t tgt,
                                       input px_t down, input px_t up);
      px_t res;
      res = cur;
      if (cur > tgt) begin
         if ((cur - tgt) <= down) res = tgt;
         else                     res = cur - down;
      end else if (cur < tgt) begin
         if ((tgt - cur) <= up) res = tgt;
         else                   res = cur + up;
      end
      return res;
   endfunction

endpackage

// File: rtl/hp_seq_div.sv
// hp_seq_div
//   Restoring divider producing one quotient bit per clock, DVD_W cycles total.
//   The first quotient bit is resolved on the start edge itself, so done is
//   high during the DVD_W-th cycle after start and the quotient is already
//   final while done is high.
//   Ports:
//     clk       in   1      clock
//     rst_n     in   1      asynchronous active-low reset
//     start     in   1      load dividend/divisor and begin
//     dividend  in   DVD_W  numerator
//     divisor   in   DVS_W  denominator (must be non-zero)
//     done      out  1      one-cycle pulse, quotient valid
//     quotient  out  DVD_W  result
module hp_seq_div #(
   parameter int DVD_W = 25,
   parameter int DVS_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             done,
   output logic [DVD_W-1:0] quotient
);

   localparam int CNT_W = $clog2(DVD_W + 1);

   logic [DVS_W-1:0] rem_q, rem_in, rem_nx, dvs_q, dvs_in;
   logic [DVD_W-1:0] quo_q, quo_in, quo_nx;
   logic [DVS_W:0]   shifted;
   logic [CNT_W-1:0] cnt_q;
   logic             active_q, done_q, fits;

   // One restoring step; on start the step works directly on the fresh operands.
   // quo holds the unconsumed dividend bits at the top and quotient bits at the bottom.
   always_comb begin
      rem_in  = start ? '0 : rem_q;
      quo_in  = start ? dividend : quo_q;
      dvs_in  = start ? divisor : dvs_q;
      shifted = {rem_in, quo_in[DVD_W-1]};
      fits    = (shifted >= {1'b0, dvs_in});
      rem_nx  = fits ? DVS_W'(shifted - {1'b0, dvs_in}) : shifted[DVS_W-1:0];
      quo_nx  = {quo_in[DVD_W-2:0], fits};
   end

   // Iteration counter and operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            rem_q    <= rem_nx;
            quo_q    <= quo_nx;
            dvs_q    <= divisor;
            cnt_q    <= CNT_W'(DVD_W - 1);
            active_q <= 1'b1;
         end else if (active_q) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               active_q <= 1'b0;
               done_q   <= 1'b1;
            end
         end
      end
   end

   assign done     = done_q;
   assign quotient = quo_q;

endmodule

// File: rtl/hpbar_anim.sv
// hpbar_anim
//   Animated HP-bar geometry for the battle HUD. A sampled (remain, total) pair
//   is turned into a target width F_WIDTH*remain/total by a multiply cycle and a
//   sequential divide; the displayed width then slides toward the target one
//   step per frame tick (DRAIN_STEP down, HEAL_STEP up).
//   Optional macro HPBAR_GHOST_EN adds a damage-trail ghost bar that holds for
//   GHOST_HOLD ticks after damage and then drains 1 px per tick; without it the
//   ghost corner simply mirrors the bar corner.
//   Ports:
//     i_clk, i_rst_n            clock, asynchronous active-low reset
//     i_tick                    one-cycle frame strobe
//     i_update                  one-cycle strobe sampling i_total_hp/i_remain_hp
//     i_total_hp, i_remain_hp   HP values (HP_W bits)
//     o_lt_x, o_lt_y            top-left corner (constant)
//     o_br_x, o_br_y            bottom-right corner; x follows the displayed width
//     o_ghost_br_x              right edge of the ghost trail
//     o_busy                    target computation in progress
//     o_settled                 displayed width equals target and not busy
//     o_low                     displayed width below LOW_W
module hpbar_anim
   import hpbar_pkg::*;
#(
`ifdef HPBAR_GHOST_EN
   parameter int GHOST_HOLD = 30,
`endif
   parameter int F_WIDTH    = 300,
   parameter int F_HEIGHT   = 16,
   parameter int FX         = 240,
   parameter int FY         = 400,
   parameter int HP_W       = 16,
   parameter int DRAIN_STEP = 2,
   parameter int HEAL_STEP  = 1,
   parameter int LOW_W      = 60
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_tick,
   input  logic            i_update,
   input  logic [HP_W-1:0] i_total_hp,
   input  logic [HP_W-1:0] i_remain_hp,
   output logic [15:0]     o_lt_x,
   output logic [15:0]     o_lt_y,
   output logic [15:0]     o_br_x,
   output logic [15:0]     o_br_y,
   output logic [15:0]     o_ghost_br_x,
   output logic            o_busy,
   output logic            o_settled,
   output logic            o_low
);

   localparam int  PW       = pw(HP_W, F_WIDTH);
   localparam px_t FULL_PX  = px_t'(F_WIDTH);
   localparam px_t DRAIN_PX = px_t'(DRAIN_STEP);
   localparam px_t HEAL_PX  = px_t'(HEAL_STEP);
   localparam px_t LOW_PX   = px_t'(LOW_W);

   state_t          state_q, state_d;
   logic [HP_W-1:0] remain_q, total_q, remain_eff;
   logic [PW-1:0]   product, quotient;
   logic            div_start, div_done;
   logic            load_inputs, write_tgt, pending_q, pending_d;
   logic            busy_q, busy_d, settled_q, settled_d, low_q, low_d;
   px_t             tgt_q, tgt_d, cur_q, cur_d, new_tgt;
   logic [15:0]     br_x_q, br_x_d;

   // Clamping remain to total keeps the quotient within F_WIDTH.
   // A zero total never starts the divider; DIV then lasts a single cycle.
   always_comb begin
      remain_eff = (remain_q > total_q) ? total_q : remain_q;
      product    = PW'(remain_eff) * PW'(F_WIDTH);
      div_start  = (state_q == MUL) && (total_q != '0);
   end

   hp_seq_div #(
      .DVD_W (PW),
      .DVS_W (HP_W)
   ) u_div (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .start    (div_start),
      .dividend (product),
      .divisor  (total_q),
      .done     (div_done),
      .quotient (quotient)
   );

   // Target written in DONE
   always_comb begin
      if (total_q == '0)                 new_tgt = '0;
      else if (quotient > PW'(F_WIDTH))  new_tgt = FULL_PX;
      else                               new_tgt = px_t'(quotient);
   end

   // Control FSM: an update arriving while busy is remembered in pending and
   // chains straight from DONE into a fresh MUL so o_busy never drops.
   always_comb begin
      state_d     = state_q;
      load_inputs = 1'b0;
      write_tgt   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_update) begin
               state_d     = MUL;
               load_inputs = 1'b1;
            end
         end
         MUL:  state_d = DIV;
         DIV: begin
            if ((total_q == '0) || div_done) state_d = DONE;
         end
         DONE: begin
            write_tgt = 1'b1;
            if (pending_q || i_update) begin
               state_d     = MUL;
               load_inputs = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Animation uses the target as registered before this edge, so a tick in
   // the DONE cycle still steps toward the old target.
   always_comb begin
      pending_d = pending_q;
      if (load_inputs)                          pending_d = 1'b0;
      else if (i_update && (state_q != IDLE))   pending_d = 1'b1;
      tgt_d     = write_tgt ? new_tgt : tgt_q;
      cur_d     = i_tick ? step_toward(cur_q, tgt_q, DRAIN_PX, HEAL_PX) : cur_q;
      busy_d    = (state_d != IDLE);
      settled_d = (cur_d == tgt_d) && !busy_d;
      low_d     = (cur_d < LOW_PX);
      br_x_d    = 16'(FX) + 16'(cur_d);
   end

   // Control and display registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         remain_q  <= '0;
         total_q   <= '0;
         pending_q <= 1'b0;
         tgt_q     <= FULL_PX;
         cur_q     <= FULL_PX;
         busy_q    <= 1'b0;
         settled_q <= 1'b1;
         low_q     <= (FULL_PX < LOW_PX);
         br_x_q    <= 16'(FX) + 16'(FULL_PX);
      end else begin
         state_q   <= state_d;
         if (load_inputs) begin
            remain_q <= i_remain_hp;
            total_q  <= i_total_hp;
         end
         pending_q <= pending_d;
         tgt_q     <= tgt_d;
         cur_q     <= cur_d;
         busy_q    <= busy_d;
         settled_q <= settled_d;
         low_q     <= low_d;
         br_x_q    <= br_x_d;
      end
   end

`ifdef HPBAR_GHOST_EN
   localparam int HOLD_W = (GHOST_HOLD > 0) ? $clog2(GHOST_HOLD + 1) : 1;

   px_t              ghost_q, ghost_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [15:0]       ghost_br_x_q, ghost_br_x_d;

   // The trail sticks to the bar while the bar is at or above it. The first
   // drop below it, or a new lower target while still holding, (re)arms the
   // hold; once the hold expires it drains 1 px per tick, which can never pass
   // below the bar because the bar is strictly lower at that point.
   always_comb begin
      ghost_d = ghost_q;
      hold_d  = hold_q;
      if (cur_d >= ghost_q) begin
         ghost_d = cur_d;
         hold_d  = '0;
      end else if (i_tick && (cur_d < cur_q) && (ghost_q == cur_q)) begin
         hold_d = HOLD_W'(GHOST_HOLD);
      end else if (write_tgt && (new_tgt < tgt_q) && (hold_q != '0)) begin
         hold_d = HOLD_W'(GHOST_HOLD);
      end else if (i_tick) begin
         if (hold_q != '0) hold_d  = hold_q - 1'b1;
         else              ghost_d = ghost_q - 1'b1;
      end
      ghost_br_x_d = 16'(FX) + 16'(ghost_d);
   end

   // Ghost trail registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ghost_q      <= FULL_PX;
         hold_q       <= '0;
         ghost_br_x_q <= 16'(FX) + 16'(FULL_PX);
      end else begin
         ghost_q      <= ghost_d;
         hold_q       <= hold_d;
         ghost_br_x_q <= ghost_br_x_d;
      end
   end

   assign o_ghost_br_x = ghost_br_x_q;
`else
   assign o_ghost_br_x = br_x_q;
`endif

   assign o_lt_x    = 16'(FX);
   assign o_lt_y    = 16'(FY);
   assign o_br_y    = 16'(FY + F_HEIGHT);
   assign o_br_x    = br_x_q;
   assign o_busy    = busy_q;
   assign o_settled = settled_q;
   assign o_low     = low_q;

endmodule

// File: tb/tb_hpbar_anim.sv
// tb_hpbar_anim
//   Directed bench for hpbar_anim with default parameters. Each update pushes
//   its expected busy length and target width onto a scoreboard; the entry is
//   popped when o_busy falls, after which the bar is ticked toward the target
//   while a small width model predicts o_br_x/o_low every tick.
//   Build with HPBAR_GHOST_EN defined to add the damage-trail scenario.
module tb_hpbar_anim;

   localparam int FX      = 240;
   localparam int F_WIDTH = 300;
   localparam int LOW_W   = 60;
   localparam int LAT     = 16 + 9 + 2;

   typedef struct {
      string tag;
      int    busy;
      int    tgt;
   } exp_t;

   logic        clk, rst_n, tick, update;
   logic [15:0] total, remain;
   logic [15:0] lt_x, lt_y, br_x, br_y, ghost_br_x;
   logic        busy, settled, low;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   model_w = F_WIDTH;
   int   model_tgt = F_WIDTH;
   exp_t sb[$];

   hpbar_anim dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_tick       (tick),
      .i_update     (update),
      .i_total_hp   (total),
      .i_remain_hp  (remain),
      .o_lt_x       (lt_x),
      .o_lt_y       (lt_y),
      .o_br_x       (br_x),
      .o_br_y       (br_y),
      .o_ghost_br_x (ghost_br_x),
      .o_busy       (busy),
      .o_settled    (settled),
      .o_low        (low)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int tgtOf(input int tot, input int rem);
      int r;
      if (tot == 0) return 0;
      r = (rem > tot) ? tot : rem;
      return (r * F_WIDTH) / tot;
   endfunction

   function automatic int latOf(input int tot);
      return (tot == 0) ? 3 : LAT;
   endfunction

   function automatic int stepOf(input int w, input int t);
      if (w > t) return (w - t <= 2) ? t : w - 2;
      if (w < t) return w + 1;
      return w;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Strobes an update (optionally a second one restart_at cycles into busy),
   // then measures the busy window and scores it against the queued entry.
   task automatic applyStimulus(input string tag, input int tot, input int rem,
                                input int restart_at, input int tot2, input int rem2);
      exp_t e;
      int   cnt;
      e.tag = tag;
      if (restart_at > 0) begin
         e.tgt  = tgtOf(tot2, rem2);
         e.busy = latOf(tot) + latOf(tot2);
      end else begin
         e.tgt  = tgtOf(tot, rem);
         e.busy = latOf(tot);
      end
      sb.push_back(e);
      update = 1'b1;
      total  = 16'(tot);
      remain = 16'(rem);
      @(negedge clk);
      update = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 300) begin
         cnt++;
         if (cnt == restart_at) begin
            update = 1'b1;
            total  = 16'(tot2);
            remain = 16'(rem2);
         end else begin
            update = 1'b0;
         end
`ifndef HPBAR_GHOST_EN
         checkOutput({tag, "_ghost_busy"}, ghost_br_x, FX + model_w);
`endif
         @(negedge clk);
      end
      update = 1'b0;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput({e.tag, "_busy_cycles"}, cnt, e.busy);
         model_tgt = e.tgt;
         checkOutput({e.tag, "_settled_at_done"}, settled, (model_w == model_tgt));
      end
   endtask

   task automatic tickOnce(input string tag);
      tick = 1'b1;
      model_w = stepOf(model_w, model_tgt);
      @(negedge clk);
      tick = 1'b0;
      checkOutput({tag, "_br_x"}, br_x, FX + model_w);
      checkOutput({tag, "_low"}, low, (model_w < LOW_W));
`ifndef HPBAR_GHOST_EN
      checkOutput({tag, "_ghost"}, ghost_br_x, FX + model_w);
`endif
   endtask

   task automatic runAnimation(input string tag);
      int guard;
      guard = 0;
      while (model_w != model_tgt && guard < 1100) begin
         tickOnce(tag);
         guard++;
      end
      checkOutput({tag, "_final_br_x"}, br_x, FX + model_tgt);
      checkOutput({tag, "_settled"}, settled, 1);
   endtask

   initial begin
      rst_n  = 1'b0;
      tick   = 1'b0;
      update = 1'b0;
      total  = '0;
      remain = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_br_x", br_x, 540);
      checkOutput("rst_ghost", ghost_br_x, 540);
      checkOutput("rst_settled", settled, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_low", low, 0);
      checkOutput("lt_x", lt_x, 240);
      checkOutput("lt_y", lt_y, 400);
      checkOutput("br_y", br_y, 416);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] half damage 50/100");
      applyStimulus("half", 100, 50, 0, 0, 0);
      runAnimation("half");
      checkOutput("half_br_x_390", br_x, 390);
      checkOutput("half_low", low, 0);

      $display("[TB] zero total");
      applyStimulus("zero_total", 0, 7, 0, 0, 0);
      runAnimation("zero_total");
      checkOutput("zero_br_x_240", br_x, 240);
      checkOutput("zero_low", low, 1);

      $display("[TB] remain above total heals to full");
      applyStimulus("over_total", 100, 200, 0, 0, 0);
      runAnimation("over_total");
      checkOutput("over_br_x_540", br_x, 540);

      $display("[TB] second update while busy");
      applyStimulus("restart", 100, 50, 5, 100, 10);
      runAnimation("restart");
      checkOutput("restart_br_x_270", br_x, 270);

      $display("[TB] async reset during divide");
      update = 1'b1;
      total  = 16'd100;
      remain = 16'd50;
      @(negedge clk);
      update = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("mid_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_br_x", br_x, 540);
      checkOutput("mid_rst_ghost", ghost_br_x, 540);
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_settled", settled, 1);
      checkOutput("mid_rst_low", low, 0);
      model_w   = F_WIDTH;
      model_tgt = F_WIDTH;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_busy", busy, 0);
      applyStimulus("full", 100, 100, 0, 0, 0);
      runAnimation("full");

`ifdef HPBAR_GHOST_EN
      $display("[TB] ghost trail");
      applyStimulus("ghost_drop", 100, 50, 0, 0, 0);
      for (int i = 0; i < 30; i++) begin
         tickOnce("ghost_hold");
         checkOutput("ghost_hold_540", ghost_br_x, 540);
      end
      for (int i = 0; i < 220; i++) tickOnce("ghost_drain");
      checkOutput("ghost_drained_390", ghost_br_x, 390);
      applyStimulus("ghost_heal", 300, 200, 0, 0, 0);
      for (int i = 0; i < 50; i++) begin
         tickOnce("ghost_heal");
         checkOutput("ghost_tracks", ghost_br_x, FX + model_w);
      end
      checkOutput("ghost_heal_440", ghost_br_x, 440);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
